// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared button FSM state type and millisecond counter width.
package stopwatch_pkg;
    typedef enum logic [1:0] {IDLE, PRESSED, HELD} btn_state_t;
    localparam int MS_W = 16;
endpackage

// File: rtl/button_events_ms_tick.sv
// ms_tick: prescaler emitting a one-cycle tick every CLK_FREQ_KHZ enabled cycles.
module ms_tick #(
    parameter int CLK_FREQ_KHZ = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = CLK_FREQ_KHZ > 1 ? $clog2(CLK_FREQ_KHZ) : 1;
    localparam logic [CW-1:0] TOP = CW'(CLK_FREQ_KHZ - 1);
    logic [CW-1:0] cnt;
    assign tick = en & ~clr & (cnt == TOP);
    always_ff @(posedge clk)
        if (rst || clr || !en) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/button_events.sv
// button_events: press/release/long-press/auto-repeat pulse generator for a debounced button.
// Define BUTTON_REPEAT_EN to enable auto-repeat; release/repeat carry an _evt suffix as both are SV keywords.
module button_events
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_KHZ = 100_000,
    parameter int LONG_MS      = 1000,
    parameter int REPEAT_MS    = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press,
    output logic release_evt,
    output logic long_press,
    output logic repeat_evt,
    output logic held
);
    localparam logic [MS_W-1:0] LONG_TOP = MS_W'(LONG_MS - 1);
    btn_state_t state, state_n;
    logic [MS_W-1:0] ms_count, ms_n;
    logic btn_q, rise, fall, tick, en, long_n, rep_n;
    assign rise = btn & ~btn_q;
    assign fall = ~btn & btn_q;
`ifdef BUTTON_REPEAT_EN
    localparam logic [MS_W-1:0] REP_TOP = MS_W'(REPEAT_MS - 1);
    assign en    = state != IDLE;
    assign rep_n = state == HELD && tick && !fall && ms_count == REP_TOP;
`else
    assign en    = state == PRESSED;
    assign rep_n = 1'b0;
`endif
    ms_tick #(.CLK_FREQ_KHZ(CLK_FREQ_KHZ)) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (rise | fall),
        .en  (en),
        .tick(tick)
    );
    always_comb begin
        long_n  = state == PRESSED && tick && !fall && ms_count == LONG_TOP;
        state_n = fall ? IDLE : rise ? PRESSED : long_n ? HELD : state;
        ms_n    = (rise || fall || long_n || rep_n) ? '0 : tick ? ms_count + 1'b1 : ms_count;
    end
    always_ff @(posedge clk)
        if (rst) begin
            state       <= IDLE;
            btn_q       <= 1'b0;
            ms_count    <= '0;
            press       <= 1'b0;
            release_evt <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
            held        <= 1'b0;
        end else begin
            state       <= state_n;
            btn_q       <= btn;
            ms_count    <= ms_n;
            press       <= rise;
            release_evt <= fall;
            long_press  <= long_n;
            repeat_evt  <= rep_n;
            held        <= state_n == HELD;
        end
endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed scoreboard bench for button_events (CLK_FREQ_KHZ=10, LONG_MS=5, REPEAT_MS=2).
module tb_button_events;
    logic clk = 1'b0;
    logic rst, btn;
    logic press, release_evt, long_press, repeat_evt, held;
    always #5 clk = ~clk;
    button_events #(.CLK_FREQ_KHZ(10), .LONG_MS(5), .REPEAT_MS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .press      (press),
        .release_evt(release_evt),
        .long_press (long_press),
        .repeat_evt (repeat_evt),
        .held       (held)
    );
    typedef struct {int t; logic [3:0] ev;} exp_t;
    localparam logic [3:0] EP = 4'b1000, ER = 4'b0100, EL = 4'b0010, EQ = 4'b0001;
    exp_t q[$];
    int n_cmp = 0, n_err = 0, cyc = 0, base = 0;
    logic [3:0] prev = '0;

    task automatic step();
        logic [3:0] ev;
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        ev = {press, release_evt, long_press, repeat_evt};
        n_cmp++;
        assert ($onehot0(ev) && (ev & prev) == 4'b0) else begin
            n_err++;
            $error("FAIL glitch t=%0d observed=%b previous=%b required onehot0 single-cycle", cyc - base, ev, prev);
        end
        prev = ev;
        if (ev != 4'b0) begin
            n_cmp++;
            assert (q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected t=%0d observed=%b required no event", cyc - base, ev);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                n_cmp++;
                assert (cyc - base === e.t && ev === e.ev) else begin
                    n_err++;
                    $error("FAIL event observed t=%0d ev=%b required t=%0d ev=%b", cyc - base, ev, e.t, e.ev);
                end
            end
        end
    endtask

    task automatic run_to(input int r);
        while (cyc < base + r) step();
    endtask

    task automatic expect_ev(input int r, input logic [3:0] e);
        q.push_back('{t: r, ev: e});
    endtask

    task automatic chk(input string tag, input logic obs, input logic req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s t=%0d observed=%b required=%b", tag, cyc - base, obs, req);
        end
    endtask

    task automatic done(input string tag);
        n_cmp++;
        assert (q.size() == 0) else begin
            n_err++;
            $error("FAIL %s_missing observed=%0d pending required=0", tag, q.size());
        end
        q.delete();
        base = cyc;
    endtask

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        repeat (3) step();
        chk("rst_press", press, 1'b0);
        chk("rst_release", release_evt, 1'b0);
        chk("rst_long", long_press, 1'b0);
        chk("rst_repeat", repeat_evt, 1'b0);
        chk("rst_held", held, 1'b0);
        rst = 1'b0;
        base = cyc;
        // short press
        run_to(10); btn = 1'b1;
        expect_ev(11, EP); expect_ev(31, ER);
        run_to(20); chk("short_held", held, 1'b0);
        run_to(30); btn = 1'b0;
        run_to(60); done("short");
        // long hold, 200 cycles
        run_to(10); btn = 1'b1;
        expect_ev(11, EP); expect_ev(61, EL);
`ifdef BUTTON_REPEAT_EN
        for (int t = 81; t <= 201; t += 20) expect_ev(t, EQ);
`endif
        expect_ev(211, ER);
        run_to(60); chk("long_held_pre", held, 1'b0);
        run_to(61); chk("long_held_rise", held, 1'b1);
        run_to(150); chk("long_held_mid", held, 1'b1);
        run_to(210); btn = 1'b0;
        run_to(211); chk("long_held_fall", held, 1'b0);
        run_to(240); done("long");
        // fall coincides with long-press tick
        run_to(10); btn = 1'b1;
        expect_ev(11, EP); expect_ev(61, ER);
        run_to(60); btn = 1'b0;
        run_to(61); chk("edge_held", held, 1'b0);
        run_to(62); chk("edge_held_next", held, 1'b0);
        run_to(90); done("edge");
        // reset during HELD with button still down
        run_to(10); btn = 1'b1;
        expect_ev(11, EP); expect_ev(61, EL);
        run_to(70); chk("rsth_held_pre", held, 1'b1);
        rst = 1'b1;
        run_to(71); chk("rsth_held_71", held, 1'b0);
        run_to(75); chk("rsth_held_75", held, 1'b0);
        rst = 1'b0;
        expect_ev(76, EP); expect_ev(126, EL);
`ifdef BUTTON_REPEAT_EN
        expect_ev(146, EQ);
`endif
        expect_ev(151, ER);
        run_to(125); chk("rsth_held_125", held, 1'b0);
        run_to(126); chk("rsth_held_126", held, 1'b1);
        run_to(150); btn = 1'b0;
        run_to(180); done("rsthold");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
